// File: rtl/reduction_engine_mc.sv
// Multi-context BF16 SUM/MAX/MIN reduction engine with one registered result slot.
// Optional feature macro: REDUCE_COUNT_EN adds a saturating per-reduction value count on result_count.

package tswitch_pkg;
  parameter int DATA_WIDTH = 16;
  parameter int TAG_WIDTH  = 8;
endpackage

module reduction_engine_mc
  import tswitch_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int NUM_CTX   = 4,
  localparam int PORT_BITS = $clog2(NUM_PORTS),
  localparam int CTX_BITS  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  value_valid,
  input  logic [DATA_WIDTH-1:0] value_data,
  input  logic [TAG_WIDTH-1:0]  value_tag,
  input  logic [1:0]            value_op,
  input  logic                  value_last,
  input  logic [PORT_BITS-1:0]  value_src_port,
  output logic                  value_ready,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic [TAG_WIDTH-1:0]  result_tag,
  output logic [PORT_BITS-1:0]  result_dst_port,
`ifdef REDUCE_COUNT_EN
  output logic [7:0]            result_count,
`endif
  input  logic                  result_ready,
  output logic                  busy,
  output logic [CTX_BITS:0]     ctx_free
);

  typedef enum logic [1:0] {
    CTX_FREE   = 2'd0,
    CTX_ACTIVE = 2'd1,
    CTX_DONE   = 2'd2
  } ctx_state_e;

  localparam logic [1:0] OP_MAX = 2'b01;
  localparam logic [1:0] OP_MIN = 2'b10;

  // Round-to-nearest-even BF16 add; subnormals flush to zero, overflow goes to infinity.
  function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, res;
    logic [7:0]  mx, my, d;
    logic [10:0] xe, ye, n;
    logic [21:0] sh;
    logic [11:0] s;
    logic signed [9:0] e;
    logic [8:0]  m;
    logic [6:0]  frac;
    logic [3:0]  lz;
    logic        found, up;
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    mx = (x[14:7] != 8'd0) ? {1'b1, x[6:0]} : 8'd0;
    my = (y[14:7] != 8'd0) ? {1'b1, y[6:0]} : 8'd0;
    d  = x[14:7] - y[14:7];
    xe = {mx, 3'b000};
    sh = {my, 3'b000, 11'd0} >> ((d > 8'd12) ? 8'd12 : d);
    ye = {sh[21:12], sh[11] | (|sh[10:0])};
    s  = (x[15] == y[15]) ? ({1'b0, xe} + {1'b0, ye}) : ({1'b0, xe} - {1'b0, ye});
    e  = signed'({2'b00, x[14:7]});
    lz = 4'd0;
    found = 1'b0;
    if (s[11]) begin
      n = {s[11:2], s[1] | s[0]};
      e = e + 10'sd1;
    end else begin
      for (int i = 10; i >= 0; i--) begin
        if (found || s[i]) found = 1'b1;
        else               lz = lz + 4'd1;
      end
      n = s[10:0] << lz;
      e = e - signed'({6'd0, lz});
    end
    up   = n[2] & (n[1] | n[0] | n[3]);
    m    = {1'b0, n[10:3]} + {8'd0, up};
    frac = m[8] ? m[7:1] : m[6:0];
    if (m[8]) e = e + 10'sd1;
    else      e = e;
    if (s == 12'd0)           res = (x[15] == y[15]) ? {x[15], 15'd0} : 16'd0;
    else if (e <= 10'sd0)     res = {x[15], 15'd0};
    else if (e >= 10'sd255)   res = {x[15], 8'hFF, 7'd0};
    else                      res = {x[15], e[7:0], frac};
    return res;
  endfunction

  // Sign-magnitude a > b with +0 == -0.
  function automatic logic bf16_gt(input logic [15:0] a, input logic [15:0] b);
    logic r;
    if (a[14:0] == 15'd0 && b[14:0] == 15'd0) r = 1'b0;
    else if (a[15] != b[15])                  r = b[15];
    else if (!a[15])                          r = (a[14:0] > b[14:0]);
    else                                      r = (a[14:0] < b[14:0]);
    return r;
  endfunction

  ctx_state_e            state_r     [NUM_CTX];
  ctx_state_e            state_nxt_s [NUM_CTX];
  logic [DATA_WIDTH-1:0] acc_r       [NUM_CTX];
  logic [DATA_WIDTH-1:0] acc_nxt_s   [NUM_CTX];
  logic [TAG_WIDTH-1:0]  tag_r       [NUM_CTX];
  logic [TAG_WIDTH-1:0]  tag_nxt_s   [NUM_CTX];
  logic [1:0]            op_r        [NUM_CTX];
  logic [1:0]            op_nxt_s    [NUM_CTX];
  logic [PORT_BITS-1:0]  dst_r       [NUM_CTX];
  logic [PORT_BITS-1:0]  dst_nxt_s   [NUM_CTX];
  logic [NUM_CTX-1:0]    issued_r, issued_nxt_s;
`ifdef REDUCE_COUNT_EN
  logic [7:0]            cnt_r       [NUM_CTX];
  logic [7:0]            cnt_nxt_s   [NUM_CTX];
  logic [7:0]            res_count_r;
`endif

  logic                  hit_s, blk_s, free_avail_s, accept_s, drain_s, load_s;
  logic [CTX_BITS-1:0]   hit_idx_s, free_idx_s, tgt_idx_s, load_idx_s;
  logic [DATA_WIDTH-1:0] sum_s, red_s, upd_s;
  logic                  res_valid_r;
  logic [DATA_WIDTH-1:0] res_data_r;
  logic [TAG_WIDTH-1:0]  res_tag_r;
  logic [PORT_BITS-1:0]  res_dst_r;
  logic [CTX_BITS-1:0]   res_ctx_r;

  // Tag lookup: active hit, blocking done match and lowest free context.
  always_comb begin
    hit_s        = 1'b0;
    hit_idx_s    = '0;
    blk_s        = 1'b0;
    free_avail_s = 1'b0;
    free_idx_s   = '0;
    for (int i = NUM_CTX - 1; i >= 0; i--) begin
      if (state_r[i] == CTX_ACTIVE && tag_r[i] == value_tag) begin
        hit_s     = 1'b1;
        hit_idx_s = CTX_BITS'(i);
      end else if (state_r[i] == CTX_DONE && tag_r[i] == value_tag) begin
        blk_s = 1'b1;
      end else if (state_r[i] == CTX_FREE) begin
        free_avail_s = 1'b1;
        free_idx_s   = CTX_BITS'(i);
      end else begin
        blk_s = blk_s;
      end
    end
    value_ready = hit_s || (!blk_s && free_avail_s);
    accept_s    = value_valid && value_ready;
    drain_s     = res_valid_r && result_ready;
    tgt_idx_s   = hit_s ? hit_idx_s : free_idx_s;
  end

  // Reduction operator applied to the hit context; a new allocation just loads the value.
  always_comb begin
    sum_s = bf16_add(acc_r[hit_idx_s], value_data);
    case (op_r[hit_idx_s])
      OP_MAX:  red_s = bf16_gt(value_data, acc_r[hit_idx_s]) ? value_data : acc_r[hit_idx_s];
      OP_MIN:  red_s = bf16_gt(acc_r[hit_idx_s], value_data) ? value_data : acc_r[hit_idx_s];
      default: red_s = sum_s;
    endcase
    upd_s = hit_s ? red_s : value_data;
  end

  // Per-context next state: accept updates the target, result handshake frees the issued one.
  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) begin
      state_nxt_s[i] = state_r[i];
      acc_nxt_s[i]   = acc_r[i];
      tag_nxt_s[i]   = tag_r[i];
      op_nxt_s[i]    = op_r[i];
      dst_nxt_s[i]   = dst_r[i];
`ifdef REDUCE_COUNT_EN
      cnt_nxt_s[i]   = cnt_r[i];
`endif
      if (accept_s && tgt_idx_s == CTX_BITS'(i)) begin
        acc_nxt_s[i]   = upd_s;
        state_nxt_s[i] = value_last ? CTX_DONE : CTX_ACTIVE;
        if (!hit_s) begin
          tag_nxt_s[i] = value_tag;
          op_nxt_s[i]  = value_op;
          dst_nxt_s[i] = value_src_port;
`ifdef REDUCE_COUNT_EN
          cnt_nxt_s[i] = 8'd1;
`endif
        end else begin
`ifdef REDUCE_COUNT_EN
          cnt_nxt_s[i] = (cnt_r[i] == 8'd255) ? 8'd255 : cnt_r[i] + 8'd1;
`endif
          op_nxt_s[i] = op_r[i];
        end
      end else if (drain_s && res_ctx_r == CTX_BITS'(i)) begin
        state_nxt_s[i] = CTX_FREE;
      end else begin
        state_nxt_s[i] = state_r[i];
      end
    end
  end

  // Slot refill picks the lowest unissued done context, including one finishing this cycle.
  always_comb begin
    load_s     = 1'b0;
    load_idx_s = '0;
    for (int i = NUM_CTX - 1; i >= 0; i--) begin
      if ((!res_valid_r || drain_s) && !issued_r[i] && state_nxt_s[i] == CTX_DONE) begin
        load_s     = 1'b1;
        load_idx_s = CTX_BITS'(i);
      end else begin
        load_s = load_s;
      end
    end
    for (int i = 0; i < NUM_CTX; i++) begin
      issued_nxt_s[i] = issued_r[i];
      if (load_s && load_idx_s == CTX_BITS'(i))           issued_nxt_s[i] = 1'b1;
      else if (drain_s && res_ctx_r == CTX_BITS'(i))      issued_nxt_s[i] = 1'b0;
      else                                                issued_nxt_s[i] = issued_r[i];
    end
  end

  // Context state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_r <= '0;
      for (int i = 0; i < NUM_CTX; i++) begin
        state_r[i] <= CTX_FREE;
        acc_r[i]   <= '0;
        tag_r[i]   <= '0;
        op_r[i]    <= 2'b00;
        dst_r[i]   <= '0;
`ifdef REDUCE_COUNT_EN
        cnt_r[i]   <= 8'd0;
`endif
      end
    end else begin
      issued_r <= issued_nxt_s;
      for (int i = 0; i < NUM_CTX; i++) begin
        state_r[i] <= state_nxt_s[i];
        acc_r[i]   <= acc_nxt_s[i];
        tag_r[i]   <= tag_nxt_s[i];
        op_r[i]    <= op_nxt_s[i];
        dst_r[i]   <= dst_nxt_s[i];
`ifdef REDUCE_COUNT_EN
        cnt_r[i]   <= cnt_nxt_s[i];
`endif
      end
    end
  end

  // Result slot register; contents hold until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_tag_r   <= '0;
      res_dst_r   <= '0;
      res_ctx_r   <= '0;
`ifdef REDUCE_COUNT_EN
      res_count_r <= 8'd0;
`endif
    end else if (load_s) begin
      res_valid_r <= 1'b1;
      res_data_r  <= acc_nxt_s[load_idx_s];
      res_tag_r   <= tag_nxt_s[load_idx_s];
      res_dst_r   <= dst_nxt_s[load_idx_s];
      res_ctx_r   <= load_idx_s;
`ifdef REDUCE_COUNT_EN
      res_count_r <= cnt_nxt_s[load_idx_s];
`endif
    end else if (drain_s) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
    end
  end

  // Occupancy status from the context states.
  always_comb begin
    busy     = 1'b0;
    ctx_free = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (state_r[i] == CTX_FREE) ctx_free = ctx_free + {{CTX_BITS{1'b0}}, 1'b1};
      else                        busy = 1'b1;
    end
  end

  assign result_valid    = res_valid_r;
  assign result_data     = res_data_r;
  assign result_tag      = res_tag_r;
  assign result_dst_port = res_dst_r;
`ifdef REDUCE_COUNT_EN
  assign result_count    = res_count_r;
`endif

endmodule

// File: tb/tb_reduction_engine_mc.sv
// Directed bench for reduction_engine_mc: table of per-cycle vectors plus hand-written
// sequences for context exhaustion, result back-pressure and mid-operation reset.

module tb_reduction_engine_mc;
  import tswitch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        value_valid, value_last, value_ready;
  logic [15:0] value_data;
  logic [7:0]  value_tag;
  logic [1:0]  value_op, value_src_port;
  logic        result_valid, result_ready, busy;
  logic [15:0] result_data;
  logic [7:0]  result_tag;
  logic [1:0]  result_dst_port;
  logic [2:0]  ctx_free;
`ifdef REDUCE_COUNT_EN
  logic [7:0]  result_count;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  reduction_engine_mc #(.NUM_PORTS(4), .NUM_CTX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .value_valid(value_valid), .value_data(value_data), .value_tag(value_tag),
    .value_op(value_op), .value_last(value_last), .value_src_port(value_src_port),
    .value_ready(value_ready),
    .result_valid(result_valid), .result_data(result_data), .result_tag(result_tag),
    .result_dst_port(result_dst_port),
`ifdef REDUCE_COUNT_EN
    .result_count(result_count),
`endif
    .result_ready(result_ready), .busy(busy), .ctx_free(ctx_free)
  );

  typedef struct {
    logic        vv;
    logic [7:0]  tag;
    logic [15:0] data;
    logic [1:0]  op;
    logic        last;
    logic [1:0]  port;
    logic        vr;
    logic        rv;
    logic [15:0] rd;
    logic [7:0]  rt;
    logic [1:0]  rp;
    logic [2:0]  fr;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(input logic vv, input logic [7:0] tag, input logic [15:0] data,
                              input logic [1:0] op, input logic last, input logic [1:0] port,
                              input logic vr, input logic rv, input logic [15:0] rd,
                              input logic [7:0] rt, input logic [1:0] rp, input logic [2:0] fr);
    vec_t v;
    v.vv = vv; v.tag = tag; v.data = data; v.op = op; v.last = last; v.port = port;
    v.vr = vr; v.rv = rv; v.rd = rd; v.rt = rt; v.rp = rp; v.fr = fr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] tag, input logic [15:0] data, input logic [1:0] op,
                     input logic last, input logic [1:0] port);
    value_valid = 1'b1; value_tag = tag; value_data = data;
    value_op = op; value_last = last; value_src_port = port;
  endtask

  task automatic idle();
    value_valid = 1'b0; value_tag = 8'd0; value_data = 16'd0;
    value_op = 2'd0; value_last = 1'b0; value_src_port = 2'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    //              vv tag   data    op last pt  vr rv  rd      rt  rp fr
    tbl[0]  = mk(1, 8'd3, 16'h3F80, 0, 0, 2, 1, 0, 16'h0000, 0, 0, 4);
    tbl[1]  = mk(1, 8'd3, 16'h4000, 0, 1, 2, 1, 0, 16'h0000, 0, 0, 3);
    tbl[2]  = mk(0, 8'd0, 16'h0000, 0, 0, 0, 1, 1, 16'h4040, 3, 2, 3);
    tbl[3]  = mk(0, 8'd0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 4);
    tbl[4]  = mk(1, 8'd7, 16'hBF80, 1, 1, 1, 1, 0, 16'h0000, 0, 0, 4);
    tbl[5]  = mk(0, 8'd0, 16'h0000, 0, 0, 0, 1, 1, 16'hBF80, 7, 1, 3);
    tbl[6]  = mk(0, 8'd0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 4);
    tbl[7]  = mk(1, 8'd1, 16'h3F80, 1, 0, 0, 1, 0, 16'h0000, 0, 0, 4);
    tbl[8]  = mk(1, 8'd2, 16'h3F00, 2, 0, 3, 1, 0, 16'h0000, 0, 0, 3);
    tbl[9]  = mk(1, 8'd1, 16'h4040, 1, 0, 0, 1, 0, 16'h0000, 0, 0, 2);
    tbl[10] = mk(1, 8'd1, 16'hBF80, 1, 1, 0, 1, 0, 16'h0000, 0, 0, 2);
    tbl[11] = mk(1, 8'd2, 16'hBF80, 2, 1, 3, 1, 1, 16'h4040, 1, 0, 2);
    tbl[12] = mk(0, 8'd0, 16'h0000, 0, 0, 0, 1, 1, 16'hBF80, 2, 3, 3);
    tbl[13] = mk(0, 8'd0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 4);
    tbl[14] = mk(1, 8'd4, 16'h4000, 3, 0, 3, 1, 0, 16'h0000, 0, 0, 4);
    tbl[15] = mk(1, 8'd4, 16'h4000, 3, 0, 3, 1, 0, 16'h0000, 0, 0, 3);
    tbl[16] = mk(1, 8'd4, 16'hBF80, 3, 1, 3, 1, 0, 16'h0000, 0, 0, 3);
    tbl[17] = mk(0, 8'd0, 16'h0000, 0, 0, 0, 1, 1, 16'h4040, 4, 3, 3);
    tbl[18] = mk(0, 8'd0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 4);
    tbl[19] = mk(1, 8'd9, 16'h8000, 1, 0, 1, 1, 0, 16'h0000, 0, 0, 4);
    tbl[20] = mk(1, 8'd9, 16'h0000, 1, 1, 1, 1, 0, 16'h0000, 0, 0, 3);
    tbl[21] = mk(0, 8'd0, 16'h0000, 0, 0, 0, 1, 1, 16'h8000, 9, 1, 3);
    tbl[22] = mk(0, 8'd0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 4);
    tbl[23] = mk(1, 8'd5, 16'h3F81, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 4);
    tbl[24] = mk(1, 8'd5, 16'h3B80, 0, 1, 0, 1, 0, 16'h0000, 0, 0, 3);
    tbl[25] = mk(0, 8'd0, 16'h0000, 0, 0, 0, 1, 1, 16'h3F82, 5, 0, 3);
    tbl[26] = mk(0, 8'd0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 4);

    rst_n = 1'b0;
    result_ready = 1'b1;
    idle();
    repeat (2) cyc();
    chk("rst_value_ready", value_ready, 1);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_data", result_data, 0);
    chk("rst_result_tag", result_tag, 0);
    chk("rst_result_dst", result_dst_port, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctx_free", ctx_free, 4);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      cyc();
      if (tbl[i].vv) put(tbl[i].tag, tbl[i].data, tbl[i].op, tbl[i].last, tbl[i].port);
      else idle();
      @(negedge clk);
      chk($sformatf("vec%0d_value_ready", i), value_ready, tbl[i].vr);
      chk($sformatf("vec%0d_result_valid", i), result_valid, tbl[i].rv);
      chk($sformatf("vec%0d_ctx_free", i), ctx_free, tbl[i].fr);
      if (tbl[i].rv) begin
        chk($sformatf("vec%0d_result_data", i), result_data, tbl[i].rd);
        chk($sformatf("vec%0d_result_tag", i), result_tag, tbl[i].rt);
        chk($sformatf("vec%0d_result_dst", i), result_dst_port, tbl[i].rp);
      end
    end

    // Exhaust all contexts, then free one by draining its result.
    for (int t = 0; t < 4; t++) begin
      cyc();
      put(8'(10 + t), 16'h3F80, 2'd0, 1'b0, 2'(t));
      @(negedge clk);
      chk($sformatf("fill%0d_ready", t), value_ready, 1);
    end
    cyc();
    put(8'd14, 16'h4000, 2'd0, 1'b0, 2'd1);
    @(negedge clk);
    chk("full_new_tag_ready", value_ready, 0);
    chk("full_ctx_free", ctx_free, 0);
    chk("full_busy", busy, 1);
    cyc();
    put(8'd10, 16'h3F80, 2'd0, 1'b1, 2'd0);
    @(negedge clk);
    chk("full_hit_ready", value_ready, 1);
    cyc();
    put(8'd14, 16'h4000, 2'd0, 1'b0, 2'd1);
    @(negedge clk);
    chk("full_result_valid", result_valid, 1);
    chk("full_result_data", result_data, 16'h4000);
    chk("full_result_tag", result_tag, 10);
    chk("full_still_stalled", value_ready, 0);
    cyc();
    @(negedge clk);
    chk("freed_ctx_ready", value_ready, 1);
    chk("freed_ctx_free", ctx_free, 1);
    for (int t = 0; t < 4; t++) begin
      cyc();
      put(8'(11 + t), 16'h3F80, 2'd0, 1'b1, 2'd0);
      @(negedge clk);
      chk($sformatf("close%0d_ready", t), value_ready, 1);
    end
    cyc();
    idle();
    n = 0;
    while (busy && n < 40) begin
      cyc();
      n++;
    end
    chk("drain_all_busy", busy, 0);
    chk("drain_all_free", ctx_free, 4);

    // Back-pressure with two finished contexts.
    cyc();
    result_ready = 1'b0;
    put(8'd20, 16'h4000, 2'd0, 1'b1, 2'd1);
    cyc();
    put(8'd21, 16'h4040, 2'd0, 1'b1, 2'd2);
    cyc();
    put(8'd21, 16'h3F80, 2'd0, 1'b0, 2'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", k), result_valid, 1);
      chk($sformatf("hold%0d_data", k), result_data, 16'h4000);
      chk($sformatf("hold%0d_tag", k), result_tag, 20);
      chk($sformatf("hold%0d_done_tag_stall", k), value_ready, 0);
      cyc();
    end
    idle();
    result_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_tag", result_tag, 20);
    chk("bp_first_dst", result_dst_port, 1);
    chk("bp_first_valid", result_valid, 1);
    cyc();
    @(negedge clk);
    chk("bp_second_valid", result_valid, 1);
    chk("bp_second_tag", result_tag, 21);
    chk("bp_second_data", result_data, 16'h4040);
    chk("bp_second_dst", result_dst_port, 2);
    cyc();
    @(negedge clk);
    chk("bp_empty_valid", result_valid, 0);
    chk("bp_empty_free", ctx_free, 4);

    // Reset in the middle of a reduction with a pending result.
    cyc();
    result_ready = 1'b0;
    put(8'd30, 16'h4000, 2'd0, 1'b0, 2'd1);
    cyc();
    put(8'd31, 16'h3F80, 2'd0, 1'b1, 2'd2);
    cyc();
    idle();
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_valid", result_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", result_valid, 0);
    chk("mid_rst_free", ctx_free, 4);
    chk("mid_rst_data", result_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    result_ready = 1'b1;
    cyc();
    put(8'd30, 16'h3F80, 2'd0, 1'b0, 2'd0);
    cyc();
    put(8'd30, 16'h3F80, 2'd0, 1'b1, 2'd3);
    cyc();
    idle();
    @(negedge clk);
    chk("restart_valid", result_valid, 1);
    chk("restart_data", result_data, 16'h4000);
    chk("restart_tag", result_tag, 30);
    chk("restart_dst", result_dst_port, 0);
`ifdef REDUCE_COUNT_EN
    chk("restart_count", result_count, 2);
`endif
    cyc();
    @(negedge clk);
    chk("final_idle_valid", result_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
